// File: rtl/vga_scanout.sv
// VGA raster scan-out: walks the video memory in raster order and drives
// pixel colour, sync and blank, with a 2-clock pipeline covering the memory read.
module vga_scanout #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [18:0] raddr,
    output logic        re,
    input  logic [5:0]  rdata,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vblank,
    output logic        frame_done
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] HVIS   = 10'(H_VIS);
    localparam logic [9:0] HLAST  = 10'(H_TOT - 1);
    localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VVIS   = 10'(V_VIS);
    localparam logic [9:0] VLAST  = 10'(V_TOT - 1);
    localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);

    logic [9:0]  h_q, h_d, v_q, v_d;
    logic [18:0] raddr_q, raddr_d;
    logic        en_q, re_q, re_d;
    logic        visible, hs_raw, vs_raw;
    logic        hs1_q, vs1_q, vis1_q;
    logic        hs2_q, vs2_q, vis2_q;
    logic [23:0] rgb_q, rgb_d;

    // Scanning only runs once en has been seen high for a clock, so the
    // first enabled clock parks at (0,0) with re already asserted.
    always_comb begin
        visible = (h_q < HVIS) && (v_q < VVIS);
        h_d     = h_q;
        v_d     = v_q;
        raddr_d = raddr_q;
        if (!en || !en_q) begin
            h_d     = '0;
            v_d     = '0;
            raddr_d = '0;
        end else begin
            if (visible) begin
                raddr_d = raddr_q + 19'd1;
            end
            if (h_q == HLAST) begin
                h_d = '0;
                if (v_q == VLAST) begin
                    v_d     = '0;
                    raddr_d = '0;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end
        re_d   = en && (h_d < HVIS) && (v_d < VVIS);
        hs_raw = !((h_q >= HS_BEG) && (h_q < HS_END));
        vs_raw = !((v_q >= VS_BEG) && (v_q < VS_END));
        rgb_d  = vis1_q ? {{4{rdata[5:4]}}, {4{rdata[3:2]}}, {4{rdata[1:0]}}} : 24'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= '0;
            v_q     <= '0;
            raddr_q <= '0;
            en_q    <= 1'b0;
            re_q    <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            raddr_q <= raddr_d;
            en_q    <= en;
            re_q    <= re_d;
        end
    end

    // Sync and blank ride alongside the memory read so they line up with rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            vis1_q <= 1'b0;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
            vis2_q <= 1'b0;
            rgb_q  <= '0;
        end else begin
            hs1_q  <= hs_raw;
            vs1_q  <= vs_raw;
            vis1_q <= re_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            vis2_q <= vis1_q;
            rgb_q  <= rgb_d;
        end
    end

    assign raddr      = raddr_q;
    assign re         = re_q;
    assign hsync      = hs2_q;
    assign vsync      = vs2_q;
    assign blank_n    = vis2_q;
    assign vga_r      = rgb_q[23:16];
    assign vga_g      = rgb_q[15:8];
    assign vga_b      = rgb_q[7:0];
    assign vblank     = (v_q >= VVIS);
    assign frame_done = (h_q == 10'd0) && (v_q == VVIS);

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a reduced-timing instance and a full 640x480 instance,
// both checked every clock against a position-based model of the raster.
module tb_vga_scanout;

    typedef struct packed {
        logic        re;
        logic [18:0] addr;
        logic        hs;
        logic        vs;
        logic        vis;
        logic [23:0] rgb;
        logic        vb;
        logic        fd;
    } desc_t;

    logic        clk;
    logic        rst_n;
    logic        enS, enF;
    logic [18:0] raddrA [2];
    logic        reA    [2];
    logic [5:0]  rdA    [2];
    logic        hsA    [2];
    logic        vsA    [2];
    logic        blA    [2];
    logic [7:0]  rA     [2];
    logic [7:0]  gA     [2];
    logic [7:0]  bA     [2];
    logic        vbA    [2];
    logic        fdA    [2];

    logic [5:0]  salt   [2];
    int          mode   [2];
    int          t      [2];
    logic        enPrev [2];
    desc_t       d0     [2];
    desc_t       d1     [2];
    desc_t       outD   [2];
    logic        chkOn;
    int          nChecks;
    int          nFail;

    vga_scanout #(
        .H_VIS(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_VIS(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dutS (
        .clk(clk), .rst_n(rst_n), .en(enS),
        .raddr(raddrA[0]), .re(reA[0]), .rdata(rdA[0]),
        .hsync(hsA[0]), .vsync(vsA[0]), .blank_n(blA[0]),
        .vga_r(rA[0]), .vga_g(gA[0]), .vga_b(bA[0]),
        .vblank(vbA[0]), .frame_done(fdA[0])
    );

    vga_scanout dutF (
        .clk(clk), .rst_n(rst_n), .en(enF),
        .raddr(raddrA[1]), .re(reA[1]), .rdata(rdA[1]),
        .hsync(hsA[1]), .vsync(vsA[1]), .blank_n(blA[1]),
        .vga_r(rA[1]), .vga_g(gA[1]), .vga_b(bA[1]),
        .vblank(vbA[1]), .frame_done(fdA[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [5:0] memVal(input int i, input logic [18:0] a);
        return (mode[i] == 1) ? 6'h3F : (a[5:0] ^ salt[i]);
    endfunction

    function automatic logic [23:0] expand(input logic [5:0] m);
        logic [7:0] r, g, b;
        r = {6'b0, m[5:4]} * 8'h55;
        g = {6'b0, m[3:2]} * 8'h55;
        b = {6'b0, m[1:0]} * 8'h55;
        return {r, g, b};
    endfunction

    // What the raster looks like at scan index tt (tt < 0 means idle at the origin).
    function automatic desc_t stageDesc(input int i, input int tt);
        desc_t d;
        int hv, hfp, hsw, hbp, vv, vfp, vsw, vbp, htot, vtot, h, v, p, a;
        if (i == 0) begin
            hv = 16;  hfp = 4;  hsw = 6;  hbp = 6;
            vv = 12;  vfp = 2;  vsw = 2;  vbp = 3;
        end else begin
            hv = 640; hfp = 16; hsw = 96; hbp = 48;
            vv = 480; vfp = 10; vsw = 2;  vbp = 33;
        end
        htot = hv + hfp + hsw + hbp;
        vtot = vv + vfp + vsw + vbp;
        h = 0;
        v = 0;
        if (tt >= 0) begin
            p = tt % (htot * vtot);
            h = p % htot;
            v = p / htot;
        end
        a      = (v < vv) ? v * hv + ((h < hv) ? h : hv) : vv * hv;
        d.re   = (tt >= 0) && (h < hv) && (v < vv);
        d.addr = 19'(a);
        d.hs   = !((h >= hv + hfp) && (h < hv + hfp + hsw));
        d.vs   = !((v >= vv + vfp) && (v < vv + vfp + vsw));
        d.vis  = d.re;
        d.rgb  = d.re ? expand(memVal(i, d.addr)) : 24'h0;
        d.vb   = (v >= vv);
        d.fd   = (h == 0) && (v == vv);
        return d;
    endfunction

    function automatic int nextT(input int i);
        logic e;
        e = (i == 0) ? enS : enF;
        if (!e) return -1;
        if (!enPrev[i]) return 0;
        return t[i] + 1;
    endfunction

    // Video memory: one-clock registered read.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdA[0] <= '0;
            rdA[1] <= '0;
        end else begin
            if (reA[0]) rdA[0] <= memVal(0, raddrA[0]);
            if (reA[1]) rdA[1] <= memVal(1, raddrA[1]);
        end
    end

    // Model: outputs show the raster position two clocks old.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                t[i]      <= -1;
                enPrev[i] <= 1'b0;
                d0[i]     <= stageDesc(i, -1);
                d1[i]     <= stageDesc(i, -1);
                outD[i]   <= stageDesc(i, -1);
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                t[i]      <= nextT(i);
                enPrev[i] <= (i == 0) ? enS : enF;
                outD[i]   <= d1[i];
                d1[i]     <= d0[i];
                d0[i]     <= stageDesc(i, nextT(i));
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (rst_n && chkOn) begin
            for (int i = 0; i < 2; i++) begin
                logic [48:0] act, exp;
                act = {reA[i], raddrA[i], hsA[i], vsA[i], blA[i],
                       rA[i], gA[i], bA[i], vbA[i], fdA[i]};
                exp = {d0[i].re, d0[i].addr, outD[i].hs, outD[i].vs, outD[i].vis,
                       outD[i].rgb, d0[i].vb, d0[i].fd};
                nChecks++;
                if (act !== exp) begin
                    nFail++;
                    $display("[TB] FAIL cycle dut%0d t=%0d got=%h expected=%h", i, t[i], act, exp);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic checkReset();
        for (int i = 0; i < 2; i++) begin
            checkOutput("rst_re", int'(reA[i]), 0);
            checkOutput("rst_raddr", int'(raddrA[i]), 0);
            checkOutput("rst_hsync", int'(hsA[i]), 1);
            checkOutput("rst_vsync", int'(vsA[i]), 1);
            checkOutput("rst_blank_n", int'(blA[i]), 0);
            checkOutput("rst_rgb", int'({rA[i], gA[i], bA[i]}), 0);
            checkOutput("rst_vblank", int'(vbA[i]), 0);
            checkOutput("rst_frame_done", int'(fdA[i]), 0);
        end
    endtask

    task automatic waitT(input int i, input int k);
        int n;
        n = 0;
        while (t[i] != k && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (t[i] != k) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL timeout dut%0d got t=%0d expected t=%0d", i, t[i], k);
        end
    endtask

    // Random enable bursts with fresh memory contents between bursts.
    task automatic applyStimulus(input int nBursts);
        for (int b = 0; b < nBursts; b++) begin
            enS = 1'b0;
            repeat (3) @(negedge clk);
            salt[0] = 6'($urandom);
            mode[0] = ($urandom_range(0, 3) == 0) ? 1 : 0;
            repeat ($urandom_range(1, 20)) @(negedge clk);
            enS = 1'b1;
            repeat ($urandom_range(50, 1500)) @(negedge clk);
        end
    endtask

    initial begin
        nChecks = 0;
        nFail   = 0;
        chkOn   = 1'b0;
        rst_n   = 1'b0;
        enS     = 1'b0;
        enF     = 1'b0;
        salt[0] = 6'($urandom);
        salt[1] = 6'h00;
        mode[0] = 0;
        mode[1] = 0;
        repeat (3) @(negedge clk);
        checkReset();
        rst_n = 1'b1;
        chkOn = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("idle_re", int'(reA[0]), 0);

        enS = 1'b1;
        enF = 1'b1;
        waitT(1, 0);
        checkOutput("start_re", int'(reA[1]), 1);
        checkOutput("start_raddr", int'(raddrA[1]), 0);
        waitT(1, 2);
        checkOutput("pix0_blank_n", int'(blA[1]), 1);
        checkOutput("pix0_rgb", int'({rA[1], gA[1], bA[1]}), 0);
        waitT(1, 3);
        checkOutput("pix1_rgb", int'({rA[1], gA[1], bA[1]}), 24'h000055);
        waitT(0, 367);
        checkOutput("last_vis_raddr", int'(raddrA[0]), 191);
        checkOutput("last_vis_re", int'(reA[0]), 1);
        waitT(0, 383);
        checkOutput("pre_vblank", int'(vbA[0]), 0);
        waitT(0, 384);
        checkOutput("vblank_rise", int'(vbA[0]), 1);
        checkOutput("frame_done_pulse", int'(fdA[0]), 1);
        waitT(0, 385);
        checkOutput("frame_done_end", int'(fdA[0]), 0);
        waitT(0, 449);
        checkOutput("vsync_pre", int'(vsA[0]), 1);
        waitT(0, 450);
        checkOutput("vsync_fall", int'(vsA[0]), 0);
        waitT(0, 513);
        checkOutput("vsync_last_low", int'(vsA[0]), 0);
        waitT(0, 514);
        checkOutput("vsync_rise", int'(vsA[0]), 1);
        waitT(0, 608);
        checkOutput("frame2_raddr", int'(raddrA[0]), 0);
        checkOutput("frame2_re", int'(reA[0]), 1);
        waitT(1, 641);
        checkOutput("blank_last", int'(blA[1]), 1);
        waitT(1, 642);
        checkOutput("blank_end", int'(blA[1]), 0);
        waitT(1, 657);
        checkOutput("hsync_pre", int'(hsA[1]), 1);
        waitT(1, 658);
        checkOutput("hsync_fall", int'(hsA[1]), 0);
        waitT(1, 753);
        checkOutput("hsync_last_low", int'(hsA[1]), 0);
        waitT(1, 754);
        checkOutput("hsync_rise", int'(hsA[1]), 1);
        waitT(1, 800);
        checkOutput("line1_raddr", int'(raddrA[1]), 640);
        checkOutput("line1_re", int'(reA[1]), 1);
        enF = 1'b0;

        waitT(0, 1384);
        enS = 1'b0;
        @(negedge clk);
        checkOutput("drop_re", int'(reA[0]), 0);
        checkOutput("drop_raddr", int'(raddrA[0]), 0);
        repeat (2) @(negedge clk);
        checkOutput("drop_blank_n", int'(blA[0]), 0);
        checkOutput("drop_rgb", int'({rA[0], gA[0], bA[0]}), 0);
        checkOutput("drop_hsync", int'(hsA[0]), 1);
        checkOutput("drop_vsync", int'(vsA[0]), 1);
        repeat (3) @(negedge clk);
        mode[0] = 1;
        enS = 1'b1;
        waitT(0, 0);
        checkOutput("restart_raddr", int'(raddrA[0]), 0);
        checkOutput("restart_re", int'(reA[0]), 1);
        waitT(0, 2);
        checkOutput("white_rgb", int'({rA[0], gA[0], bA[0]}), 24'hFFFFFF);
        waitT(0, 18);
        checkOutput("porch_rgb", int'({rA[0], gA[0], bA[0]}), 0);
        checkOutput("porch_blank_n", int'(blA[0]), 0);
        waitT(0, 700);

        applyStimulus(20);

        enF = 1'b1;
        enS = 1'b1;
        repeat (300) @(negedge clk);
        #3 rst_n = 1'b0;
        #1 checkReset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (700) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
